// File: rtl/rv32i_insn_encoder_loader.sv
// RV32I instruction encoder and sequential program-memory loader: packs field
// bundles into 32-bit words and writes them to consecutive word addresses.
module rv32i_insn_encoder_loader #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              err,
    output logic              full,
    output logic [ADDR_W-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENC  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(DEPTH_WORDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [2:0]        fmt_q;
    logic [6:0]        opcode_q;
    logic [4:0]        rd_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [6:0]        funct7_q;
    logic [31:0]       imm_q;

    logic              accept;
    logic              legal;
    logic [31:0]       enc_word;

    assign full     = (count_q == DEPTH);
    // clr takes priority over a same-cycle bundle, so ready is withheld while it is high.
    assign in_ready = (state_q == S_IDLE) && !full && !clr && !RST;
    assign accept   = in_valid && in_ready;

    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign count     = count_q;

    always_comb begin
        enc_word = '0;
        case (fmt_q)
            FMT_R: enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_I: enc_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            FMT_S: enc_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            FMT_B: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                               imm_q[4:1], imm_q[11], opcode_q};
            FMT_U: enc_word = {imm_q[31:12], rd_q, opcode_q};
            FMT_J: enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                               rd_q, opcode_q};
            default: enc_word = '0;
        endcase
    end

    // Branch and jump offsets must be halfword aligned since bit 0 is not encodable.
    always_comb begin
        legal = 1'b1;
        if (fmt_q > FMT_J) begin
            legal = 1'b0;
        end else if (((fmt_q == FMT_B) || (fmt_q == FMT_J)) && imm_q[0]) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (accept) begin
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                wdata_d = enc_word;
                if (legal) begin
                    state_d = S_WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_q + ADDR_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fmt_q    <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct7_q <= '0;
            imm_q    <= '0;
        end else if (accept) begin
            fmt_q    <= fmt;
            opcode_q <= opcode;
            rd_q     <= rd;
            funct3_q <= funct3;
            rs1_q    <= rs1;
            rs2_q    <= rs2;
            funct7_q <= funct7;
            imm_q    <= imm;
        end
    end

endmodule

// File: tb/tb_rv32i_insn_encoder_loader.sv
// Directed bench for rv32i_insn_encoder_loader: encoding vectors, handshake
// timing, illegal bundles, full/clr, ack stall and reset during a write.
module tb_rv32i_insn_encoder_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0;
    logic [2:0]        funct3 = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_ack = 1'b0;
    logic              err;
    logic              full;
    logic [ADDR_W-1:0] count;

    rv32i_insn_encoder_loader #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (0),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm       (imm),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .err       (err),
        .full      (full),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[10];

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_addr  = 0;
    int exp_count = 0;
    int exp_err   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        fmt    = v.fmt;
        opcode = v.op;
        rd     = v.rd;
        funct3 = v.f3;
        rs1    = v.rs1;
        rs2    = v.rs2;
        funct7 = v.f7;
        imm    = v.imm;
    endtask

    task automatic scramble();
        fmt    = 3'd6;
        opcode = '1;
        rd     = '1;
        funct3 = '1;
        rs1    = '1;
        rs2    = '1;
        funct7 = '1;
        imm    = '1;
    endtask

    // Accept a bundle and step into the cycle after ENC (WR for legal bundles).
    task automatic accept_bundle(input string nm, input vec_t v);
        drive(v);
        in_valid = 1'b1;
        chk({nm, "_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        scramble();
        chk({nm, "_we_enc"}, {31'b0, mem_we}, 32'd0);
        tick();
    endtask

    task automatic do_clr(input string nm);
        in_valid = 1'b1;
        clr = 1'b1;
        chk({nm, "_clr_ready"}, {31'b0, in_ready}, 32'd0);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        exp_addr = 0;
        exp_count = 0;
        exp_err = 0;
        chk({nm, "_clr_count"}, {20'b0, count}, 32'd0);
        chk({nm, "_clr_addr"}, {20'b0, mem_addr}, 32'd0);
        chk({nm, "_clr_err"}, {31'b0, err}, 32'd0);
        chk({nm, "_clr_full"}, {31'b0, full}, 32'd0);
        tick();
        chk({nm, "_clr_noaccept"}, {31'b0, mem_we}, 32'd0);
        chk({nm, "_clr_ready2"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", i);
        accept_bundle(nm, v);
        if (v.legal) begin
            chk({nm, "_we"}, {31'b0, mem_we}, 32'd1);
            chk({nm, "_wdata"}, mem_wdata, v.word);
            chk({nm, "_addr"}, {20'b0, mem_addr}, 32'(exp_addr));
            chk({nm, "_ready_wr"}, {31'b0, in_ready}, 32'd0);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            exp_addr += 4;
            exp_count++;
            chk({nm, "_we_drop"}, {31'b0, mem_we}, 32'd0);
            chk({nm, "_count"}, {20'b0, count}, 32'(exp_count));
            chk({nm, "_full"}, {31'b0, full}, (exp_count == int'(DEPTH)) ? 32'd1 : 32'd0);
            chk({nm, "_ready_after"}, {31'b0, in_ready},
                (exp_count == int'(DEPTH)) ? 32'd0 : 32'd1);
        end else begin
            exp_err = 1;
            chk({nm, "_we_ill"}, {31'b0, mem_we}, 32'd0);
            chk({nm, "_count_ill"}, {20'b0, count}, 32'(exp_count));
            chk({nm, "_ready_ill"}, {31'b0, in_ready}, 32'd1);
            tick();
            chk({nm, "_we_ill2"}, {31'b0, mem_we}, 32'd0);
        end
        chk({nm, "_err"}, {31'b0, err}, 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        //          fmt   op     rd     f3    rs1    rs2    f7     imm            legal word
        vecs[0] = '{3'd1, 7'h67, 5'd1,  3'd0, 5'd2,  5'd0,  7'd0,  32'd8,         1'b1, 32'h008100E7};
        vecs[1] = '{3'd0, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'd0,  32'd0,         1'b1, 32'h002081B3};
        vecs[2] = '{3'd5, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  7'd0,  32'hFFFFFFFC,  1'b1, 32'hFFDFF06F};
        vecs[3] = '{3'd3, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  7'd0,  32'd8,         1'b1, 32'h00000463};
        vecs[4] = '{3'd3, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  7'd0,  32'd5,         1'b0, 32'h0};
        vecs[5] = '{3'd7, 7'h33, 5'd1,  3'd0, 5'd1,  5'd1,  7'd0,  32'd0,         1'b0, 32'h0};
        vecs[6] = '{3'd2, 7'h23, 5'd0,  3'd2, 5'd6,  5'd5,  7'd0,  32'd12,        1'b1, 32'h00532623};
        vecs[7] = '{3'd4, 7'h37, 5'd5,  3'd0, 5'd0,  5'd0,  7'd0,  32'h12345000,  1'b1, 32'h123452B7};
        vecs[8] = '{3'd1, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0,  7'd0,  32'hFFFFFFFF,  1'b1, 32'hFFF00093};
        vecs[9] = '{3'd3, 7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  7'd0,  32'hFFFFFFF8,  1'b1, 32'hFE209CE3};

        tick();
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_addr", {20'b0, mem_addr}, 32'd0);
        chk("rst_count", {20'b0, count}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_ready_after", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            if (exp_count == int'(DEPTH)) begin
                in_valid = 1'b1;
                drive(vecs[0]);
                chk($sformatf("full%0d_ready", i), {31'b0, in_ready}, 32'd0);
                tick();
                in_valid = 1'b0;
                tick();
                chk($sformatf("full%0d_noaccept", i), {31'b0, mem_we}, 32'd0);
                chk($sformatf("full%0d_count", i), {20'b0, count}, 32'(DEPTH));
                do_clr($sformatf("c%0d", i));
            end
            run_vec(i, vecs[i]);
        end

        // Ack stall: write held stable for 5 cycles.
        do_clr("stall");
        v = vecs[1];
        accept_bundle("stall", v);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_we", c), {31'b0, mem_we}, 32'd1);
            chk($sformatf("stall%0d_addr", c), {20'b0, mem_addr}, 32'd0);
            chk($sformatf("stall%0d_wdata", c), mem_wdata, 32'h002081B3);
            chk($sformatf("stall%0d_ready", c), {31'b0, in_ready}, 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stall_count", {20'b0, count}, 32'd1);
        chk("stall_addr_next", {20'b0, mem_addr}, 32'd4);

        // Reset while a write is pending.
        v = vecs[0];
        accept_bundle("rstwr", v);
        chk("rstwr_we_before", {31'b0, mem_we}, 32'd1);
        RST = 1'b1;
        tick();
        chk("rstwr_we", {31'b0, mem_we}, 32'd0);
        chk("rstwr_addr", {20'b0, mem_addr}, 32'd0);
        chk("rstwr_count", {20'b0, count}, 32'd0);
        chk("rstwr_ready_rst", {31'b0, in_ready}, 32'd0);
        RST = 1'b0;
        #1;
        chk("rstwr_ready", {31'b0, in_ready}, 32'd1);
        exp_addr = 0;
        exp_count = 0;
        exp_err = 0;
        run_vec(100, vecs[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
